// File: rtl/iter_shifter.sv
// Multi-cycle barrel-free shifter: shifts a WIDTH-bit operand by up to STEP
// positions per clock. Supports SLL, SRL, SRA and ROR behind a start/busy/done handshake.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    shamt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SW-1:0]    STEP_W  = SW'(STEP);
  localparam logic [SW:0]      WIDTH_W = (SW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] ONES    = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, shifted;
  logic [SW-1:0]    rem, rem_nxt, k;
  logic [1:0]       mode_r;
  logic             sign_r;

  // Per-cycle distance: a full STEP, or whatever remains.
  always_comb begin
    k = (rem >= STEP_W) ? STEP_W : rem;
  end

  // One step of k bits in the latched mode.
  always_comb begin
    shifted = acc;
    unique case (mode_r)
      2'b00: shifted = acc << k;
      2'b01: shifted = acc >> k;
      2'b10: shifted = (acc >> k) | (sign_r ? ~(ONES >> k) : '0);
      2'b11: shifted = (acc >> k) | (acc << (WIDTH_W - {1'b0, k}));
      default: shifted = acc;
    endcase
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = data;
          rem_nxt   = shamt;
          state_nxt = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        acc_nxt = shifted;
        rem_nxt = rem - k;
        if (rem == k) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; result captures the final value on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      mode_r <= '0;
      sign_r <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      if (state == IDLE && start) begin
        mode_r <= mode;
        sign_r <= data[WIDTH-1];
      end
      // DONE is only ever entered from IDLE or SHIFT, so this fires once per op.
      if (state_nxt == DONE) result <= acc_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter (STEP=4 and STEP=1 instances).
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start4 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] data = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  mode = '0;
  logic        busy4, done4, busy1, done1;
  logic [31:0] result4, result1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iter_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start4), .data(data), .shamt(shamt),
    .mode(mode), .busy(busy4), .done(done4), .result(result4)
  );

  iter_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .data(data), .shamt(shamt),
    .mode(mode), .busy(busy1), .done(done1), .result(result1)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the selected instance in cycle 0 and observe 24 cycles.
  // Inputs are scrambled after acceptance to show they are latched.
  task automatic run_op(input bit use1, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] m, output int dcyc, output int dcnt,
                        output logic [31:0] bmask, output logic [31:0] res_done,
                        output logic [31:0] res_end);
    dcyc = -1; dcnt = 0; bmask = '0; res_done = 'x;
    data = d; shamt = s; mode = m;
    if (use1) start1 = 1'b1; else start4 = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      start1 = 1'b0; start4 = 1'b0;
      data = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
      if (use1 ? busy1 : busy4) bmask[c] = 1'b1;
      if (use1 ? done1 : done4) begin
        dcnt++;
        if (dcyc < 0) begin
          dcyc = c;
          res_done = use1 ? result1 : result4;
        end
      end
    end
    res_end = use1 ? result1 : result4;
  endtask

  // Check a completed op: done cycle, single pulse, busy window, result and hold.
  task automatic check_op(input string name, input bit use1, input logic [31:0] d,
                          input logic [4:0] s, input logic [1:0] m,
                          input int exp_cyc, input logic [31:0] exp_res);
    int dcyc, dcnt;
    logic [31:0] bm, rd, re, exp_bm;
    run_op(use1, d, s, m, dcyc, dcnt, bm, rd, re);
    exp_bm = '0;
    for (int c = 1; c <= exp_cyc; c++) exp_bm[c] = 1'b1;
    checks++;
    if (dcyc !== exp_cyc) begin
      failures++;
      $display("FAIL %s_done_cycle got=%0d exp=%0d", name, dcyc, exp_cyc);
    end
    checks++;
    if (dcnt !== 1) begin
      failures++;
      $display("FAIL %s_done_count got=%0d exp=1", name, dcnt);
    end
    checks++;
    if (bm !== exp_bm) begin
      failures++;
      $display("FAIL %s_busy_window got=%h exp=%h", name, bm, exp_bm);
    end
    checks++;
    if (rd !== exp_res) begin
      failures++;
      $display("FAIL %s_result got=%h exp=%h", name, rd, exp_res);
    end
    checks++;
    if (re !== exp_res) begin
      failures++;
      $display("FAIL %s_result_hold got=%h exp=%h", name, re, exp_res);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy4, done4, result4} !== 34'd0) begin
      failures++;
      $display("FAIL reset_s4 got busy=%b done=%b result=%h exp 0/0/0", busy4, done4, result4);
    end
    checks++;
    if ({busy1, done1, result1} !== 34'd0) begin
      failures++;
      $display("FAIL reset_s1 got busy=%b done=%b result=%h exp 0/0/0", busy1, done1, result1);
    end
  endtask

  task automatic test_srl();
    check_op("srl4", 1'b0, 32'hF000_000F, 5'd4, 2'b01, 2, 32'h0F00_0000);
  endtask

  task automatic test_sra();
    check_op("sra31", 1'b0, 32'h8000_0000, 5'd31, 2'b10, 9, 32'hFFFF_FFFF);
    check_op("sra30", 1'b0, 32'h4000_0000, 5'd30, 2'b10, 9, 32'h0000_0001);
    check_op("sra8",  1'b0, 32'h8765_4321, 5'd8,  2'b10, 3, 32'hFF87_6543);
  endtask

  task automatic test_sll();
    check_op("sll0", 1'b0, 32'hDEAD_BEEF, 5'd0, 2'b00, 1, 32'hDEAD_BEEF);
    check_op("sll5", 1'b0, 32'h0000_0001, 5'd5, 2'b00, 3, 32'h0000_0020);
  endtask

  task automatic test_ror();
    check_op("ror8",    1'b0, 32'h1234_5678, 5'd8,  2'b11, 3, 32'h7812_3456);
    check_op("ror8_s1", 1'b1, 32'h1234_5678, 5'd8,  2'b11, 9, 32'h7812_3456);
    check_op("ror31",   1'b0, 32'h0000_0001, 5'd31, 2'b11, 9, 32'h0000_0002);
    check_op("sra5_s1", 1'b1, 32'h8000_0000, 5'd5,  2'b10, 6, 32'hFC00_0000);
  endtask

  task automatic test_start_while_busy();
    int dcnt = 0, dcyc = -1;
    logic busy_after = 1'b0;
    data = 32'h0000_FFFF; shamt = 5'd16; mode = 2'b00; start4 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start4 = (c == 2 || c == 5);
      data = 32'h1234_5678; shamt = 5'd3; mode = 2'b01;
      if (done4) begin dcnt++; if (dcyc < 0) dcyc = c; end
      if (c >= 6 && busy4) busy_after = 1'b1;
    end
    start4 = 1'b0;
    checks++;
    if (dcnt !== 1 || dcyc !== 5) begin
      failures++;
      $display("FAIL busy_start_done got count=%0d cycle=%0d exp count=1 cycle=5", dcnt, dcyc);
    end
    checks++;
    if (result4 !== 32'hFFFF_0000) begin
      failures++;
      $display("FAIL busy_start_result got=%h exp=ffff0000", result4);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_dropped got busy_after=%b exp=0", busy_after);
    end
  endtask

  task automatic test_reset_mid_op();
    int dcnt = 0, dcyc;
    logic [31:0] bm, rd, re;
    data = 32'hFFFF_FFFF; shamt = 5'd20; mode = 2'b01; start4 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start4 = 1'b0;
      reset = (c == 3);
      if (c <= 3 && done4) dcnt++;
    end
    reset = 1'b0;
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL midreset_no_done got=%0d exp=0", dcnt);
    end
    checks++;
    if ({busy4, done4, result4} !== 34'd0) begin
      failures++;
      $display("FAIL midreset_state got busy=%b done=%b result=%h exp 0/0/0", busy4, done4, result4);
    end
    run_op(1'b0, 32'hF000_000F, 5'd4, 2'b01, dcyc, dcnt, bm, rd, re);
    checks++;
    if (dcyc !== 2 || rd !== 32'h0F00_0000) begin
      failures++;
      $display("FAIL midreset_restart got cycle=%0d result=%h exp cycle=2 result=0f000000", dcyc, rd);
    end
  endtask

  initial begin
    test_reset();
    test_srl();
    test_sra();
    test_sll();
    test_ror();
    test_start_while_busy();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
